pipelined_config_tree_accumulator: RTL and testbench
====================================================

// Module: pipelined_config_tree_accumulator
// PURPOSE
//  Pipelined successor of the configurable binary tree adder. Reduces INPUTS_AMOUNT packed P-bit words to one signed sum.
//  Each word is read as 1x P-bit, 2x P/2-bit or 4x P/4-bit signed lanes. The tree is registered per level.
//  A group of acc_len_i beats is accumulated before one result is emitted.
//  Sits between the PE array and the output writeback, with valid/ready on both sides.
// PARAMETERS
//  P              16  width of each packed input word (must be divisible by 4)
//  INPUTS_AMOUNT  8   words per beat (power of two, >=2)
//  OUT_W          32  width of out_o
//  ACC_LEN_W      8   width of acc_len_i
// PORTS
//  clk_i        in   1                      clock, rising edge
//  rst_ni       in   1                      synchronous active-low reset
//  in_valid_i   in   1                      input beat valid
//  in_ready_o   out  1                      input beat accepted when in_valid_i && in_ready_o
//  inputs_i     in   [INPUTS_AMOUNT][P]     packed signed words
//  mode_i       in   2                      00 full, 01 half (2 lanes), 10 quarter (4 lanes), 11 reserved = full
//  acc_len_i    in   ACC_LEN_W              beats per group; 0 treated as 1
//  out_valid_o  out  1                      result valid
//  out_ready_i  in   1                      result consumed when out_valid_o && out_ready_i
//  out_o        out  OUT_W                  signed group sum, low OUT_W bits
//  out_ovf_o    out  1                      exact group sum not representable in signed OUT_W
// BEHAVIOUR
//  - Reset (rst_ni=0 at a rising edge) sets: out_valid_o=0, out_o=0, out_ovf_o=0, in_ready_o=1.
//    It also clears all stage valids, the accumulator and the beat counter.
//    A partially accumulated group is discarded.
//  - Lane split: the upper lane sits at the MSBs, as {lane_hi, lane_lo}.
//    Each lane is sign-extended. All lanes of all words are summed into one scalar.
//  - Tree width: the tree is exact at P+$clog2(INPUTS_AMOUNT)+1 bits.
//  - Accumulator width: the internal accumulator is exact at P+$clog2(INPUTS_AMOUNT)+ACC_LEN_W+1 bits.
//    out_o is its low OUT_W bits; out_ovf_o flags a sign/range mismatch.
//  - Pipeline: D=$clog2(INPUTS_AMOUNT) registered tree levels, followed by one accumulator register.
//    Each stage carries a valid bit and a last-of-group tag.
//  - Latency: if a beat accepted at edge k closes its group, out_valid_o=1 from edge k+D+1.
//    Example: INPUTS_AMOUNT=8 gives 4 edges.
//  - Throughput: one beat per cycle while not stalled.
//  - Group state: mode_i and acc_len_i are sampled on the first beat of a group and held for the whole group.
//    Changes to either mid-group are ignored.
//    A beat counter counts accepted beats 1..len; the beat with count==len is tagged last, then the counter wraps to 0.
//  - Accumulator rule: a stage-D result tagged first-of-group loads the accumulator; otherwise it adds to it.
//    When the result is tagged last, the value is copied to out_o/out_ovf_o and out_valid_o is set.
//  - Stall: stall = out_valid_o && !out_ready_i. While stalled:
//    - the whole pipeline and the accumulator freeze;
//    - in_ready_o=0;
//    - out_o, out_ovf_o and out_valid_o are held stable.
//  - Simultaneous events: on an edge where out_ready_i=1 and a new last result reaches the accumulator, out_o updates with no bubble.
//    out_valid_o stays 1.
//  - Output clear: out_valid_o clears only on a handshake with no new result arriving on the same edge.
//  - Invalid stage: a stage with valid=0 passes a bubble. The accumulator is untouched by bubbles.
//  - Reset mid-group or mid-stall: the group is fully dropped. The next accepted beat starts a new group.
// TESTING
//  1 Full mode, acc_len=1, words 1..8 -> out_o=36, ovf=0, valid after 4 edges.
//    Words 1,-2,3,-4,5,-6,7,-8 -> -4.
//  2 Half mode, acc_len=1, lanes 1..16 packed {a,b} -> 136; lanes -1..-16 -> -136.
//    100 random beats match a scoreboard model.
//  3 Quarter mode, acc_len=1, all words 16'hFFFF -> -32.
//    Then words 16'h1234 -> 8*(1+2+3+4) = 80.
//  4 Half mode, acc_len=3, three back-to-back beats of lanes 1..16 -> one result 408.
//    Change mode_i after the first beat -> result unchanged.
//  5 Backpressure: hold out_ready_i=0 for 5 cycles with in_valid_i=1.
//    -> in_ready_o=0, out_o stable, no beat lost; release -> results in order.
//  6 OUT_W=16, full mode, acc_len=2, all words 32767 -> out_o=-16, out_ovf_o=1.
//    Assert rst_ni mid-group -> the next group's sum is uncontaminated.

Source files
------------

// File: rtl/pipelined_config_tree_accumulator_if.sv
// Handshake bundle for the pipelined configurable tree accumulator.
// master: upstream PE array + writeback side; slave: the accumulator.
//   in_valid_i/in_ready_o   input beat handshake
//   inputs_i                INPUTS_AMOUNT packed P-bit signed words
//   mode_i                  lane split (00 full, 01 half, 10 quarter, 11 full)
//   acc_len_i               beats per group (0 means 1)
//   out_valid_o/out_ready_i result handshake
//   out_o/out_ovf_o         group sum (low OUT_W bits) and range flag
interface pipelined_config_tree_accumulator_if #(
    parameter int P             = 16,
    parameter int INPUTS_AMOUNT = 8,
    parameter int OUT_W         = 32,
    parameter int ACC_LEN_W     = 8
);
    logic                              in_valid_i;
    logic                              in_ready_o;
    logic [INPUTS_AMOUNT-1:0][P-1:0]   inputs_i;
    logic [1:0]                        mode_i;
    logic [ACC_LEN_W-1:0]              acc_len_i;
    logic                              out_valid_o;
    logic                              out_ready_i;
    logic [OUT_W-1:0]                  out_o;
    logic                              out_ovf_o;

    modport master (
        output in_valid_i,
        output inputs_i,
        output mode_i,
        output acc_len_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_o,
        input  out_ovf_o
    );

    modport slave (
        input  in_valid_i,
        input  inputs_i,
        input  mode_i,
        input  acc_len_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_o,
        output out_ovf_o
    );
endinterface

// File: rtl/pipelined_config_tree_accumulator.sv
// Pipelined configurable tree accumulator: splits each word into 1/2/4
// signed lanes, reduces all lanes through a registered binary tree and
// accumulates acc_len beats per group into one signed result.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  synchronous active-low reset
//   bus     slave side of the handshake bundle (see the interface file)
module pipelined_config_tree_accumulator #(
    parameter int P             = 16,
    parameter int INPUTS_AMOUNT = 8,
    parameter int OUT_W         = 32,
    parameter int ACC_LEN_W     = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    pipelined_config_tree_accumulator_if.slave bus
);

    localparam int N   = INPUTS_AMOUNT;
    localparam int D   = $clog2(N);
    localparam int W_T = P + D + 1;
    localparam int W_A = P + D + ACC_LEN_W + 1;
    localparam int W_X = (W_A > OUT_W) ? W_A : OUT_W;
    localparam int H   = P / 2;
    localparam int Q   = P / 4;

    // Group state
    logic [1:0]           r_mode;
    logic [ACC_LEN_W-1:0] r_len;
    logic [ACC_LEN_W-1:0] r_cnt;

    // Handshake / control
    logic                 w_stall;
    logic                 w_en;
    logic                 w_accept;
    logic                 w_first;
    logic                 w_last;
    logic [1:0]           w_mode;
    logic [ACC_LEN_W-1:0] w_len;
    logic [ACC_LEN_W-1:0] w_cnt_inc;

    // Tree: heap layout, leaves N..2N-1 form level 0, node 1 is the root.
    // Every node is a register, so level l lands one edge after level l-1.
    logic signed [W_T-1:0] w_leaf [N];
    logic signed [W_T-1:0] r_node [1:2*N-1];
    logic [D:0]            r_vld;
    logic [D:0]            r_first;
    logic [D:0]            r_last;

    // Accumulator and output
    logic signed [W_A-1:0] r_acc;
    logic signed [W_A-1:0] w_root;
    logic signed [W_A-1:0] w_acc_next;
    logic signed [W_X-1:0] w_acc_x;
    logic signed [W_X-1:0] w_out_x;
    logic [OUT_W-1:0]      w_out;
    logic                  w_ovf;
    logic [OUT_W-1:0]      r_out;
    logic                  r_ovf;
    logic                  r_out_valid;

    assign w_stall  = r_out_valid && !bus.out_ready_i;
    assign w_en     = !w_stall;
    assign w_accept = bus.in_valid_i && w_en;

    assign bus.in_ready_o  = w_en;
    assign bus.out_valid_o = r_out_valid;
    assign bus.out_o       = r_out;
    assign bus.out_ovf_o   = r_ovf;

    // Mode and length come from the bus only on the first beat of a group.
    assign w_first   = (r_cnt == '0);
    assign w_mode    = w_first ? bus.mode_i : r_mode;
    assign w_len     = !w_first ? r_len :
                       (bus.acc_len_i == '0) ? ACC_LEN_W'(1) :
                       bus.acc_len_i;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_last    = (w_cnt_inc == w_len);

    // Per-word lane sum, each lane sign-extended to tree width.
    always_comb begin
        for (int w = 0; w < N; w++) begin
            w_leaf[w] = '0;
            case (w_mode)
                2'b01: begin
                    for (int j = 0; j < 2; j++) begin
                        w_leaf[w] = w_leaf[w] +
                            {{(W_T-H){bus.inputs_i[w][j*H+H-1]}},
                             bus.inputs_i[w][j*H +: H]};
                    end
                end
                2'b10: begin
                    for (int j = 0; j < 4; j++) begin
                        w_leaf[w] = w_leaf[w] +
                            {{(W_T-Q){bus.inputs_i[w][j*Q+Q-1]}},
                             bus.inputs_i[w][j*Q +: Q]};
                    end
                end
                default: begin
                    w_leaf[w] = {{(W_T-P){bus.inputs_i[w][P-1]}},
                                 bus.inputs_i[w]};
                end
            endcase
        end
    end

    assign w_root     = W_A'(r_node[1]);
    assign w_acc_next = r_first[D] ? w_root : r_acc + w_root;

    // Overflow: truncated value, sign-extended back, must equal the exact sum.
    assign w_acc_x = W_X'(w_acc_next);
    assign w_out   = w_acc_x[OUT_W-1:0];
    assign w_out_x = W_X'(signed'(w_out));
    assign w_ovf   = (w_out_x != w_acc_x);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_mode      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_vld       <= '0;
            r_first     <= '0;
            r_last      <= '0;
            r_acc       <= '0;
            r_out       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            for (int i = 1; i < 2*N; i++) begin
                r_node[i] <= '0;
            end
        end else if (w_en) begin
            if (w_accept) begin
                r_cnt <= w_last ? '0 : w_cnt_inc;
                if (w_first) begin
                    r_mode <= bus.mode_i;
                    r_len  <= w_len;
                end
            end

            r_vld   <= {r_vld[D-1:0], w_accept};
            r_first <= {r_first[D-1:0], w_first};
            r_last  <= {r_last[D-1:0], w_last};

            for (int i = 0; i < N; i++) begin
                r_node[N+i] <= w_leaf[i];
            end
            for (int i = 1; i < N; i++) begin
                r_node[i] <= r_node[2*i] + r_node[2*i+1];
            end

            if (r_vld[D]) begin
                r_acc <= w_acc_next;
                if (r_last[D]) begin
                    r_out <= w_out;
                    r_ovf <= w_ovf;
                end
            end

            // A new result wins over a same-edge handshake (no bubble).
            if (r_vld[D] && r_last[D]) begin
                r_out_valid <= 1'b1;
            end else if (bus.out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_config_tree_accumulator.sv
// Bench for pipelined_config_tree_accumulator: one 32-bit and one 16-bit
// output instance driven in lockstep, checked against a result queue.
module tb_pipelined_config_tree_accumulator;

    typedef logic [7:0][15:0] word_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    word_t      inputs;
    logic [1:0] mode;
    logic [7:0] acc_len;

    int      n_chk  = 0;
    int      n_fail = 0;
    longint  q[$];
    bit      use_model;
    int      m_cnt;
    int      m_len;
    logic [1:0] m_mode;
    longint  m_acc;

    always #5 clk = ~clk;

    pipelined_config_tree_accumulator_if #(
        .P(16), .INPUTS_AMOUNT(8), .OUT_W(32), .ACC_LEN_W(8)
    ) if32 ();
    pipelined_config_tree_accumulator_if #(
        .P(16), .INPUTS_AMOUNT(8), .OUT_W(16), .ACC_LEN_W(8)
    ) if16 ();

    assign if32.in_valid_i  = in_valid;
    assign if32.inputs_i    = inputs;
    assign if32.mode_i      = mode;
    assign if32.acc_len_i   = acc_len;
    assign if32.out_ready_i = out_ready;
    assign if16.in_valid_i  = in_valid;
    assign if16.inputs_i    = inputs;
    assign if16.mode_i      = mode;
    assign if16.acc_len_i   = acc_len;
    assign if16.out_ready_i = out_ready;

    pipelined_config_tree_accumulator #(
        .P(16), .INPUTS_AMOUNT(8), .OUT_W(32), .ACC_LEN_W(8)
    ) u_dut32 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if32.slave)
    );

    pipelined_config_tree_accumulator #(
        .P(16), .INPUTS_AMOUNT(8), .OUT_W(16), .ACC_LEN_W(8)
    ) u_dut16 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (if16.slave)
    );

    task automatic chk(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Sum of all signed lanes of one beat, straight from the lane rules.
    function automatic longint beat_sum(word_t d, logic [1:0] m);
        longint     s;
        logic [15:0] wd;
        logic [7:0]  b;
        logic [3:0]  n4;
        s = 0;
        for (int w = 0; w < 8; w++) begin
            wd = d[w];
            case (m)
                2'b01: begin
                    b = wd[15:8]; s += longint'($signed(b));
                    b = wd[7:0];  s += longint'($signed(b));
                end
                2'b10: begin
                    for (int j = 0; j < 4; j++) begin
                        n4 = wd[j*4 +: 4];
                        s += longint'($signed(n4));
                    end
                end
                default: s += longint'($signed(wd));
            endcase
        end
        return s;
    endfunction

    task automatic model_beat(input word_t d, input logic [1:0] m,
                              input logic [7:0] len);
        if (m_cnt == 0) begin
            m_mode = m;
            m_len  = (len == 0) ? 1 : int'(len);
            m_acc  = 0;
        end
        m_acc += beat_sum(d, m_mode);
        m_cnt++;
        if (m_cnt == m_len) begin
            q.push_back(m_acc);
            m_cnt = 0;
        end
    endtask

    // Entered and left at a falling edge; spans one rising edge.
    task automatic cycle(input bit v, input word_t d, input logic [1:0] m,
                         input logic [7:0] len, input bit rdy,
                         output bit acc);
        longint      e;
        logic [31:0] lo32;
        logic [15:0] lo16;
        in_valid  = v;
        inputs    = d;
        mode      = m;
        acc_len   = len;
        out_ready = rdy;
        #1;
        chk("in_ready", if32.in_ready_o, !(if32.out_valid_o && !rdy));
        acc = v && if32.in_ready_o;
        if (if32.out_valid_o) begin
            chk("valid16", if16.out_valid_o, 1);
            if (q.size() == 0) begin
                chk("spurious_valid", if32.out_valid_o, 0);
            end else begin
                e    = q[0];
                lo32 = e[31:0];
                lo16 = e[15:0];
                chk("out32", $signed(if32.out_o), $signed(lo32));
                chk("ovf32", if32.out_ovf_o,
                    e != longint'($signed(lo32)));
                chk("out16", $signed(if16.out_o), $signed(lo16));
                chk("ovf16", if16.out_ovf_o,
                    e != longint'($signed(lo16)));
                if (rdy) void'(q.pop_front());
            end
        end
        if (acc && use_model) model_beat(d, m, len);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        inputs    = '0;
        mode      = '0;
        acc_len   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", if32.out_valid_o, 0);
        chk("rst_out", if32.out_o, 0);
        chk("rst_ovf", if16.out_ovf_o, 0);
        chk("rst_ready", if32.in_ready_o, 1);
        chk("rst_valid16", if16.out_valid_o, 0);
        rst_n = 1'b1;
        q.delete();
        m_cnt = 0;
    endtask

    task automatic drain();
        bit a;
        int n;
        n = 0;
        while ((q.size() != 0 || if32.out_valid_o) && n < 60) begin
            cycle(0, '0, 2'b00, 8'd1, 1, a);
            n++;
        end
        chk("drain_queue", q.size(), 0);
        chk("drain_valid", if32.out_valid_o, 0);
    endtask

    function automatic word_t half_lanes(int sgn);
        word_t d;
        for (int w = 0; w < 8; w++) begin
            d[w] = {8'(sgn * (2*w + 1)), 8'(sgn * (2*w + 2))};
        end
        return d;
    endfunction

    function automatic word_t all_words(logic [15:0] v);
        word_t d;
        for (int w = 0; w < 8; w++) d[w] = v;
        return d;
    endfunction

    function automatic word_t rand_words();
        word_t d;
        for (int w = 0; w < 8; w++) d[w] = 16'($urandom);
        return d;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        word_t d;
        bit    acc;
        int    n;
        int    k;
        int    nst;

        use_model = 0;
        m_cnt     = 0;
        @(negedge clk);
        do_reset();

        // Full mode, words 1..8, plus latency from acceptance.
        for (int w = 0; w < 8; w++) d[w] = 16'(w + 1);
        cycle(1, d, 2'b00, 8'd1, 1, acc);
        chk("t1_accept", acc, 1);
        q.push_back(36);
        n = 0;
        while (!if32.out_valid_o && n < 20) begin
            cycle(0, '0, 2'b00, 8'd1, 1, acc);
            n++;
        end
        chk("t1_latency", n, 4);
        for (int w = 0; w < 8; w++) begin
            d[w] = (w % 2 == 0) ? 16'(w + 1) : 16'(-(w + 1));
        end
        cycle(1, d, 2'b00, 8'd1, 1, acc);
        q.push_back(-4);
        drain();

        // Half mode, lanes 1..16 and -1..-16 back to back.
        cycle(1, half_lanes(1), 2'b01, 8'd1, 1, acc);
        q.push_back(136);
        cycle(1, half_lanes(-1), 2'b01, 8'd1, 1, acc);
        q.push_back(-136);
        drain();

        // Half mode random beats against the model.
        use_model = 1;
        for (int i = 0; i < 100; i++) begin
            cycle(1, rand_words(), 2'b01, 8'd1, 1, acc);
        end
        drain();
        use_model = 0;

        // Quarter mode.
        cycle(1, all_words(16'hFFFF), 2'b10, 8'd1, 1, acc);
        q.push_back(-32);
        cycle(1, all_words(16'h1234), 2'b10, 8'd1, 1, acc);
        q.push_back(80);
        drain();

        // Three-beat group; mode/len changes after the first are ignored.
        cycle(1, half_lanes(1), 2'b01, 8'd3, 1, acc);
        cycle(1, half_lanes(1), 2'b10, 8'd9, 1, acc);
        cycle(1, half_lanes(1), 2'b10, 8'd9, 1, acc);
        q.push_back(408);
        drain();

        // Backpressure: 5 stalled cycles, no beat lost, order kept.
        k   = 1;
        nst = 0;
        for (int c = 0; c < 60 && k <= 8; c++) begin
            cycle(1, all_words(16'(k)), 2'b00, 8'd1,
                  !(c >= 4 && c <= 9), acc);
            if (acc) begin
                q.push_back(8 * k);
                k++;
            end else begin
                nst++;
            end
        end
        chk("t5_beats", k, 9);
        chk("t5_stalls", nst, 5);
        drain();

        // Overflow on the 16-bit instance.
        cycle(1, all_words(16'd32767), 2'b00, 8'd2, 1, acc);
        cycle(1, all_words(16'd32767), 2'b00, 8'd2, 1, acc);
        q.push_back(524272);
        drain();

        // Reset mid-group drops the partial group.
        cycle(1, all_words(16'd7), 2'b00, 8'd2, 1, acc);
        do_reset();
        cycle(1, all_words(16'd1), 2'b00, 8'd2, 1, acc);
        cycle(1, all_words(16'd1), 2'b00, 8'd2, 1, acc);
        q.push_back(16);
        drain();

        // Mixed random traffic: modes, group lengths, valid and ready.
        use_model = 1;
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_words(),
                  2'($urandom), 8'($urandom_range(0, 4)),
                  $urandom_range(0, 3) != 0, acc);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
